// File: rtl/debouncer_pkg.sv
// Shared helpers for the multi-channel debouncer: cycle conversion, idle raw
// levels and the auto-repeat state encoding.
package debouncer_pkg;

  localparam logic RAW_IDLE_ACTIVE_LOW  = 1'b1;
  localparam logic RAW_IDLE_ACTIVE_HIGH = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Raw pin level seen while the button is not pressed.
  function automatic logic raw_idle(input int active_low);
    return (active_low != 0) ? RAW_IDLE_ACTIVE_LOW : RAW_IDLE_ACTIVE_HIGH;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer_multi_channel.sv
// One debounced button: two-flop synchroniser, stability filter, press/release
// pulses and, with DEBOUNCER_AUTO_REPEAT_EN defined, the auto-repeat FSM.
module debounce_channel
  import debouncer_pkg::*;
#(
  parameter int ACTIVE_LOW = 1,
  parameter int DB_CYCLES  = 4
`ifdef DEBOUNCER_AUTO_REPEAT_EN
  ,
  parameter int RD_CYCLES  = 1,
  parameter int RP_CYCLES  = 1
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic IDLE_RAW = raw_idle(ACTIVE_LOW);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          act;
  logic          differ;
  logic          qualify;
  logic          rise;
  logic          fall;
  logic          press_next;

  assign act     = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;
  assign differ  = (act != level);
  assign qualify = differ && (cnt == DB_LAST);
  assign rise    = qualify && act;
  assign fall    = qualify && !act;

`ifdef DEBOUNCER_AUTO_REPEAT_EN
  localparam int RCW = $clog2(max_int(RD_CYCLES, RP_CYCLES) + 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(RD_CYCLES - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(RP_CYCLES - 1);

  rep_state_t     rstate;
  logic [RCW-1:0] rcnt;
  logic           rep_fire;

  // A release in the same cycle suppresses any repeat that falls due.
  always_comb begin
    rep_fire = 1'b0;
    if (!fall) begin
      case (rstate)
        ST_DELAY:  rep_fire = (rcnt == RD_LAST);
        ST_REPEAT: rep_fire = (rcnt == RP_LAST);
        default:   rep_fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate <= ST_IDLE;
      rcnt   <= '0;
    end else if (fall) begin
      rstate <= ST_IDLE;
      rcnt   <= '0;
    end else if (rise) begin
      rstate <= ST_DELAY;
      rcnt   <= '0;
    end else begin
      case (rstate)
        ST_DELAY: begin
          if (rep_fire) begin
            rstate <= ST_REPEAT;
            rcnt   <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (rep_fire) rcnt <= '0;
          else          rcnt <= rcnt + 1'b1;
        end
        default: begin
          rstate <= ST_IDLE;
          rcnt   <= '0;
        end
      endcase
    end
  end

  assign press_next = rise | rep_fire;
`else
  assign press_next = rise;
`endif

  // Synchroniser (p0 -> p1), then filter and pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= IDLE_RAW;
      sync_p1 <= IDLE_RAW;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      press   <= press_next;
      rel     <= fall;
      if (qualify) begin
        level <= act;
        cnt   <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/debouncer_multi.sv
// N independent debounced buttons with press/release pulses and any_press.
// Optional auto-repeat on held buttons: define DEBOUNCER_AUTO_REPEAT_EN.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int N_CH             = 4,
  parameter int CLK_HZ           = 50_000_000,
  parameter int DEBOUNCE_MS      = 20,
  parameter int ACTIVE_LOW       = 1,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_press
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int RD_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RP_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS);

  if (N_CH < 1) begin : g_bad_nch
    $error("debouncer_multi: N_CH must be >= 1");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("debouncer_multi: debounce time must be at least one clock cycle");
  end
  if (RD_CYCLES < 1 || RP_CYCLES < 1) begin : g_bad_rep
    $error("debouncer_multi: repeat delay and period must be at least one clock cycle");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW (ACTIVE_LOW),
      .DB_CYCLES  (DB_CYCLES)
`ifdef DEBOUNCER_AUTO_REPEAT_EN
      ,
      .RD_CYCLES  (RD_CYCLES),
      .RP_CYCLES  (RP_CYCLES)
`endif
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_in[g]),
      .level (btn_level[g]),
      .press (press_pulse[g]),
      .rel   (release_pulse[g])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: directed scenarios plus random buttons and resets,
// every cycle compared against a sliding-window reference model.
module tb_debouncer_multi;

  localparam int N_CH = 4;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic            any_press;

  debouncer_multi #(
    .N_CH             (N_CH),
    .CLK_HZ           (1000),
    .DEBOUNCE_MS      (4),
    .ACTIVE_LOW       (1),
    .REPEAT_DELAY_MS  (10),
    .REPEAT_PERIOD_MS (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_press     (any_press)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  // Reference model: level flips when the last DB filter observations all disagree.
  logic [N_CH-1:0] m_level = '0;
  logic [N_CH-1:0] m_press = '0;
  logic [N_CH-1:0] m_rel   = '0;
  logic [DB-1:0]   win [N_CH];
  logic [N_CH-1:0] raw_h1 = '1;
  logic [N_CH-1:0] raw_h2 = '1;
  bit              rst_h1 = 1'b1;
  bit              rst_h2 = 1'b1;
  int              q_edge [N_CH];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic model_step(input logic [N_CH-1:0] raw, input logic rst_ok);
    logic o;
`ifdef DEBOUNCER_AUTO_REPEAT_EN
    int d;
`endif
    edge_cnt++;
    m_press = '0;
    m_rel   = '0;
    if (!rst_ok) begin
      m_level = '0;
      for (int ch = 0; ch < N_CH; ch++) win[ch] = '0;
    end else begin
      for (int ch = 0; ch < N_CH; ch++) begin
        o = (rst_h1 || rst_h2) ? 1'b0 : ~raw_h2[ch];
        win[ch] = {win[ch][DB-2:0], o};
        if (m_level[ch] ? (win[ch] == '0) : (win[ch] == '1)) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) begin
            m_press[ch] = 1'b1;
            q_edge[ch]  = edge_cnt;
          end else begin
            m_rel[ch] = 1'b1;
          end
        end
`ifdef DEBOUNCER_AUTO_REPEAT_EN
        else if (m_level[ch]) begin
          d = edge_cnt - q_edge[ch];
          if (d == RD || (d > RD && (d - RD) % RP == 0)) m_press[ch] = 1'b1;
        end
`endif
      end
    end
    raw_h2 = raw_h1;
    raw_h1 = raw;
    rst_h2 = rst_h1;
    rst_h1 = !rst_ok;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(btn_in, rst_n);
    @(negedge clk);
    chk("level", int'(btn_level), int'(m_level));
    chk("press", int'(press_pulse), int'(m_press));
    chk("release", int'(release_pulse), int'(m_rel));
    chk("any_press", int'(any_press), int'(|m_press));
    chk("press_and_release", int'(press_pulse & release_pulse), 0);
  endtask

  task automatic wait_pulse(input int ch, input bit want_rel, output int e);
    e = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (want_rel ? release_pulse[ch] : press_pulse[ch]) begin
        e = edge_cnt;
        break;
      end
    end
  endtask

  int e;
  int t0;
  int seen;
  int np;
  int first;
  int hold [N_CH];

  initial begin
    for (int ch = 0; ch < N_CH; ch++) begin
      win[ch]    = '0;
      q_edge[ch] = 0;
      hold[ch]   = 0;
    end
    btn_in = '1;
    rst_n  = 1'b0;
    repeat (3) cycle();
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_any", int'(any_press), 0);
    rst_n = 1'b1;
    repeat (4) cycle();

    // Clean press on ch0
    btn_in[0] = 1'b0;
    t0 = edge_cnt + 1;
    wait_pulse(0, 1'b0, e);
    chk("press_latency", e - t0, DB + 1);
    chk("press_any", int'(any_press), 1);
    chk("press_others", int'(btn_level[3:1]), 0);
    cycle();
    chk("press_one_cycle", int'(press_pulse[0]), 0);

    // Bounce on ch1 never qualifies
    seen = 0;
    for (int i = 0; i < 19; i++) begin
      btn_in[1] = (i == 3 || i >= 7) ? 1'b1 : 1'b0;
      cycle();
      seen |= int'(btn_level[1] | press_pulse[1] | release_pulse[1]);
    end
    chk("bounce_ch1", seen, 0);

    // Release ch0
    btn_in[0] = 1'b1;
    t0 = edge_cnt + 1;
    wait_pulse(0, 1'b1, e);
    chk("release_latency", e - t0, DB + 1);
    chk("release_level", int'(btn_level[0]), 0);
    chk("release_no_press", int'(press_pulse[0]), 0);
    cycle();
    chk("release_one_cycle", int'(release_pulse[0]), 0);

    // Simultaneous press on ch2 and ch3
    repeat (3) cycle();
    btn_in[3:2] = 2'b00;
    wait_pulse(2, 1'b0, e);
    chk("simul_press", int'(press_pulse[3:2]), 3);
    chk("simul_any", int'(any_press), 1);
    cycle();
    chk("simul_one_cycle", int'(press_pulse), 0);
    btn_in[3:2] = 2'b11;
    repeat (10) cycle();

    // Reset while ch0 counter is at 2
    btn_in[0] = 1'b0;
    repeat (4) cycle();
    rst_n = 1'b0;
    cycle();
    chk("midrst_outputs", int'(btn_level | press_pulse | release_pulse), 0);
    rst_n = 1'b1;
    t0 = edge_cnt + 1;
    wait_pulse(0, 1'b0, e);
    chk("requal_latency", e - t0, DB + 1);

    // Hold ch0: repeats only with auto-repeat
    np = 0;
    first = -1;
    for (int i = 0; i < 17; i++) begin
      cycle();
      if (press_pulse[0]) begin
        if (first < 0) first = edge_cnt - e;
        np++;
      end
    end
`ifdef DEBOUNCER_AUTO_REPEAT_EN
    chk("repeat_count", np, 3);
    chk("repeat_first", first, RD);
`else
    chk("no_repeat", np, 0);
`endif
    btn_in[0] = 1'b1;
    wait_pulse(0, 1'b1, e);
    chk("hold_release_seen", int'(e > 0), 1);
    np = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      np += int'(press_pulse[0]);
    end
    chk("no_press_after_release", np, 0);

    // Random buttons with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if (hold[ch] == 0) begin
          btn_in[ch] = 1'($urandom_range(0, 1));
          hold[ch]   = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 5);
        end else begin
          hold[ch]--;
        end
      end
      rst_n = ($urandom_range(0, 249) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
